// File: rtl/upsample_engine_if.sv
// Handshake bundle for the 2x upsampler: pixel stream in, pixel stream out, frame-done pulse.
// The slave modport is the engine's view; the master modport is the surrounding pipeline's view.
interface upsample_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         valid_in;
  logic                         ready_in;
  logic signed [DATA_WIDTH-1:0] pixel_in;
  logic                         valid_out;
  logic                         ready_out;
  logic signed [DATA_WIDTH-1:0] pixel_out;
  logic                         all_done;

  modport master (
    output valid_in, pixel_in, ready_out,
    input  ready_in, valid_out, pixel_out, all_done
  );

  modport slave (
    input  valid_in, pixel_in, ready_out,
    output ready_in, valid_out, pixel_out, all_done
  );
endinterface

// File: rtl/upsample_engine.sv
// 2x nearest-neighbour upsampler (UPSAMPLE_ZERO_FILL_EN: zero-insertion unpool), raster in / raster out.
// Latency 1 cycle; a stalled output holds pixel_out/valid_out and blocks input; odd rows replay the line buffer.
module upsample_engine #(
  parameter int MAP_WIDTH  = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  upsample_engine_if.slave   bus
);
  localparam int CW = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAP_WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                col, row;
  logic                         dup;
  logic                         row_in_done;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] pixel_out;
  logic                         all_done;
  logic                         ready_in;
  logic                         in_fire, out_fire, second_fire;

  assign in_fire     = bus.valid_in && ready_in;
  assign out_fire    = valid_out && bus.ready_out;
  assign second_fire = out_fire && dup;

  assign bus.ready_in  = ready_in;
  assign bus.valid_out = valid_out;
  assign bus.pixel_out = pixel_out;
  assign bus.all_done  = all_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EVEN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EVEN:    if (second_fire && row_in_done) state_nxt = ODD;
      ODD:     if (second_fire && col == LAST) state_nxt = EVEN;
      default: state_nxt = EVEN;
    endcase
  end

  // Once the last pixel of a row is taken, input stays closed until the odd row has replayed.
  always_comb begin
    ready_in = 1'b0;
    if (!rst && state == EVEN && !row_in_done)
      ready_in = !valid_out || (bus.ready_out && dup);
  end

`ifndef UPSAMPLE_ZERO_FILL_EN
  logic signed [DATA_WIDTH-1:0] line_buf [MAP_WIDTH];

  always_ff @(posedge clk) begin
    if (in_fire) line_buf[col] <= bus.pixel_in;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out   <= 1'b0;
      pixel_out   <= '0;
      dup         <= 1'b0;
      col         <= '0;
      row         <= '0;
      row_in_done <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      all_done <= 1'b0;
      if (state == EVEN) begin
        if (in_fire) begin
          pixel_out <= bus.pixel_in;
          valid_out <= 1'b1;
          dup       <= 1'b0;
          if (col == LAST) begin
            col         <= '0;
            row_in_done <= 1'b1;
          end else begin
            col <= col + ONE;
          end
        end else if (out_fire && !dup) begin
          dup <= 1'b1;
`ifdef UPSAMPLE_ZERO_FILL_EN
          pixel_out <= '0;
`endif
        end else if (second_fire) begin
          if (row_in_done) begin
            // Straight into the odd row with no bubble.
`ifdef UPSAMPLE_ZERO_FILL_EN
            pixel_out <= '0;
`else
            pixel_out <= line_buf[0];
`endif
            valid_out   <= 1'b1;
            dup         <= 1'b0;
            col         <= '0;
            row_in_done <= 1'b0;
          end else begin
            valid_out <= 1'b0;
          end
        end
      end else begin
        if (out_fire && !dup) begin
          dup <= 1'b1;
        end else if (second_fire) begin
          dup <= 1'b0;
          if (col == LAST) begin
            valid_out <= 1'b0;
            col       <= '0;
            if (row == LAST) begin
              row      <= '0;
              all_done <= 1'b1;
            end else begin
              row <= row + ONE;
            end
          end else begin
            col <= col + ONE;
`ifndef UPSAMPLE_ZERO_FILL_EN
            pixel_out <= line_buf[col + ONE];
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_upsample_engine.sv
// Bench for upsample_engine: fixed 2x2 vectors on a MAP_WIDTH=2 instance, randomized frames on a
// MAP_WIDTH=14 instance checked against a raster-index model of 2x upsampling.
module tb_upsample_engine;
  localparam int MW = 14;
  localparam int NIN = MW * MW;
  localparam int NOUT = 4 * MW * MW;
`ifdef UPSAMPLE_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  upsample_engine_if #(.DATA_WIDTH(8)) b2 ();
  upsample_engine_if #(.DATA_WIDTH(8)) b14 ();

  upsample_engine #(.MAP_WIDTH(2),  .DATA_WIDTH(8)) dut2  (.clk(clk), .rst(rst), .bus(b2));
  upsample_engine #(.MAP_WIDTH(MW), .DATA_WIDTH(8)) dut14 (.clk(clk), .rst(rst), .bus(b14));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:3][7:0]  pin;
    logic [0:15][7:0] pexp;
  } vec_t;

  vec_t tbl [3];
  logic signed [7:0] frame [NIN];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic run_w2(input int v);
    int n_in, cyc, done_cnt, last;
    logic signed [7:0] got [$];
    n_in = 0; cyc = 0; done_cnt = 0; last = -1;
    while (cyc < 200) begin
      @(negedge clk);
      b2.ready_out = 1'b1;
      b2.valid_in  = (n_in < 4);
      b2.pixel_in  = tbl[v].pin[(n_in < 4) ? n_in : 0];
      #1;
      if (b2.all_done) done_cnt++;
      if (b2.valid_in && b2.ready_in) n_in++;
      if (b2.valid_out && b2.ready_out) begin
        got.push_back(b2.pixel_out);
        last = cyc;
      end
      cyc++;
      if (got.size() == 16 && cyc > last + 3) break;
    end
    b2.valid_in = 1'b0;
    chk(got.size() == 16, $sformatf("w2_v%0d_count", v), got.size(), 16);
    for (int k = 0; k < 16; k++)
      if (k < got.size())
        chk(got[k] == $signed(tbl[v].pexp[k]), $sformatf("w2_v%0d_out%0d", v, k),
            got[k], $signed(tbl[v].pexp[k]));
    chk(done_cnt == 1, $sformatf("w2_v%0d_all_done", v), done_cnt, 1);
  endtask

  // Stream one random frame into the 14-wide engine; abort_at >= 0 stops after that many accepts.
  task automatic run_frame(input int rdy_pct, input int vld_pct, input int abort_at,
                           input bit timing_chk, input string tag);
    int n_in, n_out, cyc, first_acc, first_out, last_out, done_cnt, done_cyc;
    int kr, kc, exp_slot, act_slot, oy, ox, expv;
    bit stalled, aborted;
    logic signed [7:0] held;
    logic signed [7:0] got [$];
    for (int i = 0; i < NIN; i++) frame[i] = 8'($urandom);
    n_in = 0; n_out = 0; cyc = 0; first_acc = -1; first_out = -1; last_out = -1;
    done_cnt = 0; done_cyc = -1; stalled = 1'b0; aborted = 1'b0; held = '0;
    while (cyc < 20000) begin
      @(negedge clk);
      b14.ready_out = ($urandom_range(99) < rdy_pct);
      b14.valid_in  = (n_in < NIN) && ($urandom_range(99) < vld_pct);
      b14.pixel_in  = b14.valid_in ? frame[n_in] : 8'($urandom);
      #1;
      if (stalled)
        chk(b14.valid_out && b14.pixel_out == held, {tag, "_stall_hold"}, b14.pixel_out, held);
      if (b14.all_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (b14.valid_in && b14.ready_in) begin
        // An input may only land once every output before its 2x2 block has gone out.
        kr = n_in / MW;
        kc = n_in % MW;
        exp_slot = 4 * MW * kr + 2 * kc;
        act_slot = n_out + ((b14.valid_out && b14.ready_out) ? 1 : 0);
        chk(act_slot == exp_slot, {tag, "_accept_slot"}, act_slot, exp_slot);
        if (first_acc < 0) first_acc = cyc;
        n_in++;
      end
      if (b14.valid_out && b14.ready_out) begin
        got.push_back(b14.pixel_out);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      stalled = b14.valid_out && !b14.ready_out;
      held    = b14.pixel_out;
      cyc++;
      if (abort_at >= 0 && n_in >= abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (n_out == NOUT && cyc >= last_out + 3) break;
    end
    if (!aborted) begin
      b14.valid_in  = 1'b0;
      b14.ready_out = 1'b1;
      chk(n_out == NOUT, {tag, "_out_count"}, n_out, NOUT);
      for (int k = 0; k < NOUT; k++) begin
        if (k < got.size()) begin
          oy = k / (2 * MW);
          ox = k % (2 * MW);
          expv = frame[(oy / 2) * MW + ox / 2];
          if (ZF && !((oy % 2 == 0) && (ox % 2 == 0))) expv = 0;
          chk(got[k] == expv, $sformatf("%s_out%0d", tag, k), got[k], expv);
        end
      end
      chk(done_cnt == 1, {tag, "_all_done_count"}, done_cnt, 1);
      chk(done_cyc == last_out + 1, {tag, "_all_done_cycle"}, done_cyc, last_out + 1);
      if (timing_chk) begin
        chk(first_out == first_acc + 1, {tag, "_latency"}, first_out - first_acc, 1);
        chk(last_out - first_out + 1 == NOUT + MW - 1, {tag, "_span"},
            last_out - first_out + 1, NOUT + MW - 1);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    if (ZF) begin
      tbl[0] = '{pin: {8'h01, 8'hFE, 8'h03, 8'h80},
                 pexp: {8'h01, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h03, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
      tbl[1] = '{pin: {8'h7F, 8'hFF, 8'h00, 8'h05},
                 pexp: {8'h7F, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
      tbl[2] = '{pin: {8'h80, 8'h7F, 8'h80, 8'h7F},
                 pexp: {8'h80, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h80, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    end else begin
      tbl[0] = '{pin: {8'h01, 8'hFE, 8'h03, 8'h80},
                 pexp: {8'h01, 8'h01, 8'hFE, 8'hFE, 8'h01, 8'h01, 8'hFE, 8'hFE,
                        8'h03, 8'h03, 8'h80, 8'h80, 8'h03, 8'h03, 8'h80, 8'h80}};
      tbl[1] = '{pin: {8'h7F, 8'hFF, 8'h00, 8'h05},
                 pexp: {8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'hFF, 8'hFF,
                        8'h00, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00, 8'h05, 8'h05}};
      tbl[2] = '{pin: {8'h80, 8'h7F, 8'h80, 8'h7F},
                 pexp: {8'h80, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h7F, 8'h7F,
                        8'h80, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h7F, 8'h7F}};
    end

    rst = 1'b1;
    b2.valid_in = 1'b0;  b2.pixel_in = '0;  b2.ready_out = 1'b1;
    b14.valid_in = 1'b0; b14.pixel_in = '0; b14.ready_out = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk(b14.ready_in == 1'b0, "rst_ready_in", b14.ready_in, 0);
    chk(b14.valid_out == 1'b0, "rst_valid_out", b14.valid_out, 0);
    chk(b14.pixel_out == 0, "rst_pixel_out", b14.pixel_out, 0);
    chk(b14.all_done == 1'b0, "rst_all_done", b14.all_done, 0);
    chk(b2.ready_in == 1'b0, "rst_w2_ready_in", b2.ready_in, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(b14.ready_in == 1'b1, "idle_ready_in", b14.ready_in, 1);

    for (int v = 0; v < 3; v++) run_w2(v);

    run_frame(100, 100, -1, 1'b1, "cont");
    run_frame(50, 100, -1, 1'b0, "bp");
    run_frame(100, 60, -1, 1'b0, "gaps");
    run_frame(50, 60, -1, 1'b0, "mixed");

    run_frame(100, 100, 30, 1'b0, "abort");
    @(posedge clk);
    #1;
    chk(b14.valid_out == 1'b1, "pre_reset_valid", b14.valid_out, 1);
    b14.valid_in = 1'b0;
    rst = 1'b1;
    #1;
    chk(b14.valid_out == 1'b0, "async_rst_valid_out", b14.valid_out, 0);
    chk(b14.ready_in == 1'b0, "async_rst_ready_in", b14.ready_in, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(b14.pixel_out == 0, "post_rst_pixel_out", b14.pixel_out, 0);
    run_frame(70, 80, -1, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/upsample_engine.md
# upsample_engine

Streaming 2x nearest-neighbour upsampler, the inverse-direction companion of the maxpool engine. It consumes a raster-order MAP_WIDTH x MAP_WIDTH signed feature map and emits a raster-order (2·MAP_WIDTH) x (2·MAP_WIDTH) map, replicating each input pixel into a 2x2 block. It sits on the decoder/expansion path of the accelerator. It uses a one-row line buffer with valid/ready flow control on both sides, because output rate is 4x input rate.

## Interface
- MAP_WIDTH, 14: input map side length (≥1); output side = 2·MAP_WIDTH.
- DATA_WIDTH, 8: signed pixel width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  input pixel valid.
- ready_in  out  1  engine accepts pixel this cycle (combinational from state; forced 0 while rst).
- pixel_in  in  DATA_WIDTH  signed input pixel, raster order.
- valid_out  out  1  output pixel valid.
- ready_out  in  1  downstream accepts output.
- pixel_out  out  DATA_WIDTH  signed output pixel, raster order.
- all_done  out  1  one-cycle pulse after final output of a frame.

## Operation
- Transfer occurs when valid && ready on the same edge (in: valid_in&&ready_in; out: valid_out&&ready_out).
- Output register (pixel_out, valid_out) plus dup bit (0 = first copy, 1 = second copy); line_buf[MAP_WIDTH] (not reset); counters col (0..MAP_WIDTH-1), row (0..MAP_WIDTH-1).
- States: EVEN (output row 2r, accepts input), ODD (output row 2r+1, replays line_buf, no input).
- EVEN: ready_in = !valid_out || (ready_out && dup==1). On accept: pixel_out<=pixel_in, line_buf[col]<=pixel_in, valid_out<=1, dup<=0, col++. Output fire with dup==0 -> dup<=1. Fire with dup==1 and no accept -> valid_out<=0.
- EVEN->ODD: when second copy of col MAP_WIDTH-1 fires: pixel_out<=line_buf[0], valid_out<=1, dup<=0, col<=0 (no bubble).
- ODD: each pixel emitted twice from line_buf; after second copy of col c fires, load line_buf[c+1] same edge. After second copy of col MAP_WIDTH-1 fires: valid_out<=0, go EVEN; row++ or, if row==MAP_WIDTH-1, row<=0 and pulse all_done next cycle.
- No state crosses frames; next frame starts immediately in EVEN.
- Data passed unmodified (no arithmetic); signedness preserved.
- Reset mid-frame: all counters, state=EVEN, valid_out=0 immediately (async); partial frame discarded.

## Timing
- Reset values: valid_out=0, pixel_out=0, all_done=0, ready_in=0 during rst, state=EVEN, col=row=dup=0.
- Latency: accepted pixel on pixel_out the next cycle.
- Throughput with ready_out=1: EVEN accepts 1 pixel / 2 cycles (back-to-back, no bubbles); ODD 2·MAP_WIDTH cycles with no input; exactly one bubble cycle at ODD->EVEN.
- Frame with continuous valid_in and ready_out=1: 4·MAP_WIDTH² output cycles + MAP_WIDTH-1 bubbles between row pairs.
- valid_out && !ready_out: pixel_out and valid_out held stable.
- all_done: registered, asserted exactly one cycle, on the cycle after the final output fire.

## Configuration
- UPSAMPLE_ZERO_FILL_EN defined: zero-insertion unpool. Only the top-left of each 2x2 block carries the pixel; the second copy in EVEN and all ODD outputs are 0. The line buffer is not instantiated. Handshake and timing are identical.
- Undefined (default): nearest-neighbour replication as above.

## Test plan
- MAP_WIDTH=2, input [1,-2,3,-128], ready_out=1 -> 16 outputs 1,1,-2,-2,1,1,-2,-2,3,3,-128,-128,3,3,-128,-128; all_done pulses once.
- MAP_WIDTH=14, random signed frame -> 784 outputs match the golden 2x replication; all_done exactly once; one bubble per ODD->EVEN.
- Random 50% ready_out backpressure -> pixel_out stable while stalled; same 784 outputs; no loss or duplication.
- Random valid_in gaps -> correct output; ready_in never high in ODD; no input is accepted while the second copy is stalled.
- After 30 inputs, assert rst for 2 cycles -> valid_out=0 immediately; the following full frame is correct with a single all_done.
- UPSAMPLE_ZERO_FILL_EN, MAP_WIDTH=2, input [1,-2,3,-128] -> 1,0,-2,0,0,0,0,0,3,0,-128,0,0,0,0,0.
